// File: rtl/delta_sequencer_if.sv
// Control-only bundle between the Delta phase sequencer and its surroundings:
// batch control, the three-way upstream join, and the two-way downstream fork.
interface delta_sequencer_if #(
  parameter int NB = 4
);
  localparam int WC = $clog2(NB + 1);

  logic          iStart;
  logic          iTrain;
  logic          oMode;
  logic          oBusy;
  logic          oDone;
  logic          iValid_AS_Accum1;
  logic          oReady_AS_Accum1;
  logic          iValid_AS_Weight;
  logic          oReady_AS_Weight;
  logic          iValid_AS_Delta0;
  logic          oReady_AS_Delta0;
  logic          oLoad;
  logic          oValid_BM_Delta0;
  logic          iReady_BM_Delta0;
  logic          oValid_BM_Delta1;
  logic          iReady_BM_Delta1;
  logic [WC-1:0] oCount;

  // The sequencer owns the outputs.
  modport master (
    input  iStart, iTrain,
    input  iValid_AS_Accum1, iValid_AS_Weight, iValid_AS_Delta0,
    input  iReady_BM_Delta0, iReady_BM_Delta1,
    output oMode, oBusy, oDone, oLoad, oCount,
    output oReady_AS_Accum1, oReady_AS_Weight, oReady_AS_Delta0,
    output oValid_BM_Delta0, oValid_BM_Delta1
  );

  modport slave (
    output iStart, iTrain,
    output iValid_AS_Accum1, iValid_AS_Weight, iValid_AS_Delta0,
    output iReady_BM_Delta0, iReady_BM_Delta1,
    input  oMode, oBusy, oDone, oLoad, oCount,
    input  oReady_AS_Accum1, oReady_AS_Weight, oReady_AS_Delta0,
    input  oValid_BM_Delta0, oValid_BM_Delta1
  );
endinterface

// File: rtl/delta_sequencer.sv
// Handshake and phase controller for one layer's Delta datapath: joins three
// upstream streams into one load, forks it to two consumers, counts a batch.
module delta_sequencer #(
  parameter string HIDDEN = "yes",
  parameter int    NB     = 4
) (
  input  logic               iCLK,
  input  logic               iRST,
  delta_sequencer_if.master  bus
);

  localparam int            WC        = $clog2(NB + 1);
  localparam bit            UseDelta1 = (HIDDEN == "yes");
  localparam logic [WC-1:0] LastCount = WC'(NB - 1);
  localparam logic [WC-1:0] FullCount = WC'(NB);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic          vld0_q, vld0_d;
  logic          vld1_q, vld1_d;
  logic          busy_q, done_q;
  logic [WC-1:0] count_q, count_d;
  logic          allValid, free, fire;

  // A join fires only when every upstream is valid and both fork slots can take
  // the result, so no stream is ever consumed alone.
  always_comb begin
    allValid = bus.iValid_AS_Accum1 & bus.iValid_AS_Weight & bus.iValid_AS_Delta0;
    free     = (~vld0_q | bus.iReady_BM_Delta0) & (~vld1_q | bus.iReady_BM_Delta1);
    fire     = (state_q == RUN) & allValid & free;

    vld0_d   = fire | (vld0_q & ~bus.iReady_BM_Delta0);
    vld1_d   = UseDelta1 & (fire | (vld1_q & ~bus.iReady_BM_Delta1));

    state_d  = state_q;
    mode_d   = mode_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        if (bus.iStart) begin
          state_d = RUN;
          mode_d  = bus.iTrain;
          count_d = '0;
        end
      end
      RUN: begin
        if (fire) begin
          if (count_q != FullCount) count_d = count_q + 1'b1;
          if (count_q == LastCount) state_d = FLUSH;
        end
      end
      // Leave as soon as the last result drains, not one cycle later.
      FLUSH: begin
        if (!vld0_d && !vld1_d) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      vld0_q  <= vld0_d;
      vld1_q  <= vld1_d;
      busy_q  <= (state_d == RUN) || (state_d == FLUSH);
      done_q  <= (state_d == DONE);
      count_q <= count_d;
    end
  end

  assign bus.oReady_AS_Accum1 = fire;
  assign bus.oReady_AS_Weight = fire;
  assign bus.oReady_AS_Delta0 = fire;
  assign bus.oLoad            = fire;
  assign bus.oValid_BM_Delta0 = vld0_q;
  assign bus.oValid_BM_Delta1 = vld1_q;
  assign bus.oMode            = mode_q;
  assign bus.oBusy            = busy_q;
  assign bus.oDone            = done_q;
  assign bus.oCount           = count_q;

endmodule
